inst_rom_resp: RTL and testbench
================================

INST_ROM_RESP -- requirements
Module: inst_rom_resp

Interface
REQ-001 The block SHALL expose parameter DEPTH_LOG2, default 10, the log2 of the word depth of the instruction store (1024 words).
REQ-002 The block SHALL expose parameter WAIT_CYCLES, default 2, the number of wait-state cycles inserted per fetch; legal range 0..15.
REQ-003 The block SHALL use clock clk, rising edge; all state updates occur on this edge.
REQ-004 The block SHALL use reset rst, synchronous, active-high.
REQ-005 Ports SHALL be, as name  direction  width  meaning:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ce  in  1  fetch request strobe from the PC stage
- addr  in  32  byte address of the requested instruction
- inst  out  32  fetched instruction word
- inst_valid  out  1  inst and addr_err are valid this cycle
- busy  out  1  fetch in progress; ce is not sampled
- addr_err  out  1  the responded request was misaligned
- ld_we  in  1  loader write enable
- ld_addr  in  DEPTH_LOG2  loader word index
- ld_data  in  32  loader write data

Function
REQ-006 The store SHALL be a 2^DEPTH_LOG2 x 32 array, indexed by addr[DEPTH_LOG2+1:2]; upper address bits are ignored (the address space wraps modulo store size).
REQ-007 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-008 In IDLE or RESP, ce=1 at an edge SHALL accept a request: the address is captured and the wait counter is loaded with WAIT_CYCLES.
REQ-009 After acceptance: WAIT_CYCLES=0 -> RESP next cycle; otherwise WAIT, decrementing once per cycle, then RESP on the cycle the counter expires.
REQ-010 A request accepted at edge N SHALL produce inst_valid=1 during cycle N+1+WAIT_CYCLES, for exactly one cycle.
REQ-011 In RESP with ce=0, the FSM SHALL return to IDLE; with ce=1, a new request is accepted, so WAIT_CYCLES=0 sustains one fetch per cycle.
REQ-012 busy SHALL be 1 in WAIT and 0 in IDLE and RESP.
REQ-013 ce SHALL be ignored while in WAIT; no request is queued.
REQ-014 The array word SHALL be read on the edge that enters RESP and be driven on inst.
REQ-015 inst SHALL hold its last value after inst_valid deasserts.
REQ-016 A captured address with addr[1:0]!=0 SHALL still take the full latency, but respond with inst=0 and addr_err=1; otherwise addr_err=0.
REQ-017 An ld_we=1 edge SHALL write ld_data to word ld_addr, in any FSM state.
REQ-018 A write to the word being read on the same edge SHALL return the old data (read-before-write); the new data is visible to later fetches.
REQ-019 The wait counter SHALL be 4 bits and never underflow.

Reset
REQ-020 rst=1 at an edge SHALL force IDLE, inst=0, inst_valid=0, busy=0, addr_err=0 and counter=0.
REQ-021 Any in-flight request SHALL be discarded by reset and never produce inst_valid.
REQ-022 ce SHALL be ignored while rst=1.
REQ-023 ld_we SHALL be ignored while rst=1.
REQ-024 Array contents SHALL NOT be cleared by reset.

Verification
REQ-025 With WAIT_CYCLES=2: load word 1 with 0x3C011234, ce=1 with addr=0x4 for one cycle at edge N -> busy=1 in cycles N+1..N+2, inst_valid=1 with inst=0x3C011234 in cycle N+3.
REQ-026 With WAIT_CYCLES=0: ce held 1, addr=0,4,8 on consecutive edges -> inst_valid=1 on three consecutive cycles, returning words 0, 1 and 2 in order.
REQ-027 With WAIT_CYCLES=2: addr=0x6 -> after 3 cycles, inst_valid=1, inst=0x00000000, addr_err=1.
REQ-028 With DEPTH_LOG2=10: addr=0x00001004 -> returns word 1 (wrap).
REQ-029 With WAIT_CYCLES=2: rst=1 during WAIT -> no inst_valid pulse; all outputs are 0 on the next cycle; a subsequent fetch completes normally.
REQ-030 With WAIT_CYCLES=0: ld_we writes word 5 with 0xAAAA0000 on the edge that reads word 5 (previously 0x55550000) -> returns 0x55550000; a refetch returns 0xAAAA0000.

Source files
------------

// File: rtl/inst_rom_resp.sv
// Instruction store with a fixed-latency fetch port and a side-band loader.
// Each accepted fetch responds exactly WAIT_CYCLES+1 cycles later with a one-cycle inst_valid.
module inst_rom_resp #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [31:0]           addr,
    output logic [31:0]           inst,
    output logic                  inst_valid,
    output logic                  busy,
    output logic                  addr_err,
    input  logic                  ld_we,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic [31:0]           ld_data
);

    localparam int         AW      = DEPTH_LOG2 + 2;
    localparam int         DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     inst_q, inst_d;
    logic            inst_valid_q, inst_valid_d;
    logic            addr_err_q, addr_err_d;
    logic            enter_resp;
    logic [AW-1:0]   rd_addr;
    logic [31:0]     rd_word;

    logic [31:0]     mem_q [DEPTH];

    // Bits above the store index are intentionally ignored: the space wraps.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:AW];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        enter_resp = 1'b0;
        rd_addr    = addr_q;
        case (state_q)
            IDLE, RESP: begin
                if (ce) begin
                    addr_d = addr[AW-1:0];
                    cnt_d  = WAIT_LD;
                    if (WAIT_LD == 4'd0) begin
                        // Zero wait states: read straight from the incoming address.
                        state_d    = RESP;
                        enter_resp = 1'b1;
                        rd_addr    = addr[AW-1:0];
                    end else begin
                        state_d = WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0)
                    cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rd_word = mem_q[rd_addr[AW-1:2]];

    always_comb begin
        inst_d       = inst_q;
        inst_valid_d = enter_resp;
        addr_err_d   = 1'b0;
        if (enter_resp) begin
            addr_err_d = (rd_addr[1:0] != 2'b00);
            inst_d     = (rd_addr[1:0] != 2'b00) ? 32'h0 : rd_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            addr_q       <= '0;
            inst_q       <= 32'h0;
            inst_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            addr_err_q   <= addr_err_d;
        end
    end

    // Non-blocking write alongside the registered read gives read-before-write.
    always_ff @(posedge clk) begin
        if (!rst && ld_we)
            mem_q[ld_addr] <= ld_data;
    end

    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign addr_err   = addr_err_q;
    assign busy       = (state_q == WAIT);

endmodule

// File: tb/tb_inst_rom_resp.sv
// Bench for inst_rom_resp: two instances (2 and 0 wait states) against a latency/scoreboard model.
module tb_inst_rom_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce      [2];
    logic [31:0] addr    [2];
    logic        ld_we   [2];
    logic [9:0]  ld_addr [2];
    logic [31:0] ld_data [2];
    logic [31:0] inst    [2];
    logic        iv      [2];
    logic        busy    [2];
    logic        aerr    [2];

    always #5 clk = ~clk;

    inst_rom_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst(rst), .ce(ce[0]), .addr(addr[0]), .inst(inst[0]),
        .inst_valid(iv[0]), .busy(busy[0]), .addr_err(aerr[0]),
        .ld_we(ld_we[0]), .ld_addr(ld_addr[0]), .ld_data(ld_data[0]));

    inst_rom_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .ce(ce[1]), .addr(addr[1]), .inst(inst[1]),
        .inst_valid(iv[1]), .busy(busy[1]), .addr_err(aerr[1]),
        .ld_we(ld_we[1]), .ld_addr(ld_addr[1]), .ld_data(ld_data[1]));

    // Reference model: each request is just a due cycle plus an address.
    int          wc [2] = '{2, 0};
    logic [31:0] rmem [2][1024];
    bit          pend [2];
    int          due  [2];
    logic [31:0] paddr [2];
    logic [31:0] e_inst [2];
    bit          e_iv [2], e_busy [2], e_err [2];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit r;
        r = rst;
        for (int d = 0; d < 2; d++) begin
            if (r) begin
                pend[d] = 0; e_iv[d] = 0; e_inst[d] = 0; e_err[d] = 0; e_busy[d] = 0;
            end else begin
                if (ce[d] && !(pend[d] && cyc < due[d])) begin
                    pend[d]  = 1;
                    due[d]   = cyc + 1 + wc[d];
                    paddr[d] = addr[d];
                end
                if (pend[d] && due[d] == cyc + 1) begin
                    e_iv[d]   = 1;
                    e_err[d]  = (paddr[d][1:0] != 2'b00);
                    e_inst[d] = e_err[d] ? 32'h0 : rmem[d][paddr[d][11:2]];
                end else begin
                    e_iv[d]  = 0;
                    e_err[d] = 0;
                end
                e_busy[d] = pend[d] && (cyc + 1 < due[d]);
                if (ld_we[d]) rmem[d][ld_addr[d]] = ld_data[d];
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_valid", d), 32'(iv[d]), 32'(e_iv[d]));
            chk($sformatf("d%0d_busy", d), 32'(busy[d]), 32'(e_busy[d]));
            chk($sformatf("d%0d_inst", d), inst[d], e_inst[d]);
            if (e_iv[d] || r) chk($sformatf("d%0d_err", d), 32'(aerr[d]), 32'(e_err[d]));
        end
    endtask

    task automatic clear_inputs();
        for (int d = 0; d < 2; d++) begin
            ce[d] = 0; addr[d] = 0; ld_we[d] = 0; ld_addr[d] = 0; ld_data[d] = 0;
        end
    endtask

    task automatic load(input int d, input int idx, input logic [31:0] data);
        ld_we[d] = 1; ld_addr[d] = 10'(idx); ld_data[d] = data;
        step();
        ld_we[d] = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [31:0] a;
        rst = 1;
        clear_inputs();
        idle(2);
        chk("reset_inst", inst[0], 32'h0);
        chk("reset_valid", 32'(iv[0]), 32'h0);
        rst = 0;

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++) load(d, i, $urandom);

        // Two wait states: busy for two cycles, then the word.
        load(0, 1, 32'h3C011234);
        ce[0] = 1; addr[0] = 32'h4; step(); ce[0] = 0;
        chk("w2_busy1", 32'(busy[0]), 32'h1);
        step(); chk("w2_busy2", 32'(busy[0]), 32'h1);
        step();
        chk("w2_valid", 32'(iv[0]), 32'h1);
        chk("w2_inst", inst[0], 32'h3C011234);
        step(); chk("w2_hold", inst[0], 32'h3C011234);

        // Back-to-back fetches with zero wait states.
        load(1, 0, 32'h11110000); load(1, 1, 32'h22220000); load(1, 2, 32'h33330000);
        ce[1] = 1; addr[1] = 32'h0; step(); chk("w0_seq0", inst[1], 32'h11110000);
        addr[1] = 32'h4; step(); chk("w0_seq1", inst[1], 32'h22220000);
        addr[1] = 32'h8; step(); chk("w0_seq2", inst[1], 32'h33330000);
        chk("w0_seq_valid", 32'(iv[1]), 32'h1);
        ce[1] = 0; step();

        // Misaligned fetch keeps the full latency and flags an error.
        ce[0] = 1; addr[0] = 32'h6; step(); ce[0] = 0; idle(2);
        chk("mis_valid", 32'(iv[0]), 32'h1);
        chk("mis_inst", inst[0], 32'h0);
        chk("mis_err", 32'(aerr[0]), 32'h1);

        // Upper address bits wrap.
        ce[0] = 1; addr[0] = 32'h00001004; step(); ce[0] = 0; idle(2);
        chk("wrap_inst", inst[0], 32'h3C011234);
        step();

        // Reset during WAIT discards the request; a later fetch still works.
        ce[0] = 1; addr[0] = 32'h4; step(); ce[0] = 0;
        rst = 1; step(); rst = 0;
        chk("rst_busy", 32'(busy[0]), 32'h0);
        chk("rst_inst", inst[0], 32'h0);
        idle(3);
        ce[0] = 1; addr[0] = 32'h4; step(); ce[0] = 0; idle(2);
        chk("post_rst_inst", inst[0], 32'h3C011234);
        step();

        // Same-edge write returns old data; refetch sees the new word.
        load(1, 5, 32'h55550000);
        ce[1] = 1; addr[1] = 32'h14;
        ld_we[1] = 1; ld_addr[1] = 10'd5; ld_data[1] = 32'hAAAA0000;
        step(); ld_we[1] = 0;
        chk("rbw_old", inst[1], 32'h55550000);
        step(); ce[1] = 0;
        chk("rbw_new", inst[1], 32'hAAAA0000);
        step();

        // Randomized traffic, loads and occasional resets.
        for (int i = 0; i < 500; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            for (int d = 0; d < 2; d++) begin
                ce[d] = $urandom_range(0, 1) == 1;
                a = $urandom;
                a[11:2] = 10'($urandom_range(0, 15));
                a[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                addr[d] = a;
                ld_we[d] = ($urandom_range(0, 4) == 0);
                ld_addr[d] = 10'($urandom_range(0, 15));
                ld_data[d] = $urandom;
            end
            step();
        end
        rst = 0;
        clear_inputs();
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
